// File: rtl/game_pkg.sv
// Shared encodings and constants for the falling-item game engine: game states,
// colour codes, LFSR seed/taps and default screen geometry.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        COL_RED    = 2'd0,
        COL_GREEN  = 2'd1,
        COL_BLUE   = 2'd2,
        COL_YELLOW = 2'd3
    } item_color_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int DEF_X_MIN     = 64;
    localparam int DEF_FLOOR_Y   = 460;
    localparam int DEF_FALL_STEP = 2;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/drop_engine_if.sv
// Control/status bundle between the drop engine and its surroundings
// (tick divider, collision logic, draw block).
interface drop_engine_if #(
    parameter int N_ITEMS = 4,
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int SCORE_W = 14
);
    logic                   fall_tick;
    logic                   start;
    logic                   pause;
    logic [N_ITEMS-1:0]     catch_hit;
    logic [N_ITEMS-1:0]     item_active;
    logic [N_ITEMS*X_W-1:0] item_x;
    logic [N_ITEMS*Y_W-1:0] item_y;
    logic [N_ITEMS*2-1:0]   item_color;
    logic [SCORE_W-1:0]     score;
    logic [1:0]             lives;
    logic [1:0]             game_state;
    logic                   miss_pulse;

    modport slave (
        input  fall_tick, start, pause, catch_hit,
        output item_active, item_x, item_y, item_color, score, lives, game_state, miss_pulse
    );

    modport master (
        output fall_tick, start, pause, catch_hit,
        input  item_active, item_x, item_y, item_color, score, lives, game_state, miss_pulse
    );
endinterface

// File: rtl/drop_slot.sv
// One falling-item slot: holds active/x/y/colour and resolves
// clear > load > hit > miss > move each clock, reporting a miss combinationally.
module drop_slot #(
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int FLOOR_Y = 460
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           en,
    input  logic           load,
    input  logic [X_W-1:0] load_x,
    input  logic [1:0]     load_color,
    input  logic           hit,
    input  logic           tick,
    input  logic [Y_W-1:0] step,
    output logic           active,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [1:0]     color,
    output logic           miss
);
    localparam logic [Y_W-1:0] FLOOR = Y_W'(FLOOR_Y);

    assign miss = en & active & ~hit & (y >= FLOOR);

    // NOTE: non-blocking assignments so every slot register updates from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            x      <= '0;
            y      <= '0;
            color  <= '0;
        end else if (clear) begin
            active <= 1'b0;
            x      <= '0;
            y      <= '0;
            color  <= '0;
        end else if (en) begin
            // The arbiter only loads free slots, so load never collides with hit/miss.
            if (load) begin
                active <= 1'b1;
                x      <= load_x;
                y      <= '0;
                color  <= load_color;
            end else if (active && hit) begin
                active <= 1'b0;
            end else if (miss) begin
                active <= 1'b0;
            end else if (active && tick) begin
                y <= y + step;
            end
        end
    end
endmodule

// File: rtl/drop_engine.sv
// Game-state FSM, LFSR spawner, score/lives for N_ITEMS falling slots.
// Define SPEEDUP_EN to make the fall step grow with the score.
module drop_engine
    import game_pkg::*;
#(
    parameter int N_ITEMS   = 4,
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int X_MIN     = DEF_X_MIN,
    parameter int X_SPAN_LG = 9,
    parameter int FLOOR_Y   = DEF_FLOOR_Y,
    parameter int FALL_STEP = DEF_FALL_STEP,
    parameter int SPAWN_GAP = 40,
    parameter int LIVES     = 3,
    parameter int SCORE_W   = 14
) (
    input  logic          clk,
    input  logic          rst,
    drop_engine_if.slave  bus
);
    localparam int                CNT_W    = $clog2(SPAWN_GAP + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SPAWN_GAP - 1);

    game_state_t          state, state_next;
    logic                 start_q, start_rise;
    logic [15:0]          lfsr;
    logic [CNT_W-1:0]     count;
    logic [SCORE_W-1:0]   score, score_after;
    logic [SCORE_W:0]     score_sum;
    logic [1:0]           lives, lives_after;
    logic                 miss_pulse, play, init, game_over;
    logic [3:0]           hit_cnt, miss_cnt;
    logic [N_ITEMS-1:0]   active, valid_hit, miss, load;
    logic [N_ITEMS*X_W-1:0] x_v;
    logic [N_ITEMS*Y_W-1:0] y_v;
    logic [N_ITEMS*2-1:0]   color_v;
    logic [X_W-1:0]       spawn_x;
    logic [Y_W-1:0]       step;
    logic                 found;

    assign start_rise = bus.start & ~start_q;
    assign play       = (state == ST_PLAY);
    assign valid_hit  = bus.catch_hit & active & {N_ITEMS{play}};
    assign spawn_x    = X_W'(X_MIN) + X_W'(lfsr[X_SPAN_LG-1:0]);

`ifdef SPEEDUP_EN
    int boost;
    always_comb begin
        boost = int'(score[SCORE_W-1:4]) + FALL_STEP;
        step  = (boost > 4 * FALL_STEP) ? Y_W'(4 * FALL_STEP) : Y_W'(boost);
    end
`else
    assign step = Y_W'(FALL_STEP);
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit_cnt  = '0;
        miss_cnt = '0;
        load     = '0;
        found    = 1'b0;
        for (int i = 0; i < N_ITEMS; i++) begin
            hit_cnt  = hit_cnt + {3'b000, valid_hit[i]};
            miss_cnt = miss_cnt + {3'b000, miss[i]};
            // Lowest free slot wins; slots freed this clock are still marked active.
            if (play && count == CNT_LAST && !found && !active[i]) begin
                load[i] = 1'b1;
                found   = 1'b1;
            end
        end
        score_sum   = {1'b0, score} + {{(SCORE_W - 3){1'b0}}, hit_cnt};
        score_after = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        lives_after = ({2'b00, lives} > miss_cnt) ? lives - miss_cnt[1:0] : 2'd0;
    end

    always_comb begin
        state_next = state;
        init       = 1'b0;
        game_over  = 1'b0;
        unique case (state)
            ST_IDLE: if (start_rise) begin
                state_next = ST_PLAY;
                init       = 1'b1;
            end
            ST_PLAY: if (lives_after == 2'd0) begin
                state_next = ST_OVER;
                game_over  = 1'b1;
            end else if (bus.pause) begin
                state_next = ST_PAUSE;
            end
            ST_PAUSE: if (!bus.pause) state_next = ST_PLAY;
            ST_OVER:  if (start_rise) state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            start_q    <= 1'b0;
            lfsr       <= LFSR_SEED;
            count      <= '0;
            score      <= '0;
            lives      <= '0;
            miss_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            start_q    <= bus.start;
            miss_pulse <= play && (|miss);
            if (init) begin
                score <= '0;
                lives <= 2'(LIVES);
                count <= '0;
            end else if (play) begin
                lfsr  <= lfsr_next(lfsr);
                score <= score_after;
                lives <= lives_after;
                if (|load)
                    count <= '0;
                else if (bus.fall_tick && count != CNT_LAST)
                    count <= count + CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < N_ITEMS; i++) begin : g_slot
        drop_slot #(.X_W(X_W), .Y_W(Y_W), .FLOOR_Y(FLOOR_Y)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .clear      (init | game_over),
            .en         (play),
            .load       (load[i]),
            .load_x     (spawn_x),
            .load_color (lfsr[15:14]),
            .hit        (bus.catch_hit[i]),
            .tick       (bus.fall_tick),
            .step       (step),
            .active     (active[i]),
            .x          (x_v[i*X_W +: X_W]),
            .y          (y_v[i*Y_W +: Y_W]),
            .color      (color_v[i*2 +: 2]),
            .miss       (miss[i])
        );
    end

    assign bus.item_active = active;
    assign bus.item_x      = x_v;
    assign bus.item_y      = y_v;
    assign bus.item_color  = color_v;
    assign bus.score       = score;
    assign bus.lives       = lives;
    assign bus.game_state  = state;
    assign bus.miss_pulse  = miss_pulse;
endmodule

// File: tb/tb_drop_engine.sv
// Self-checking bench for drop_engine: directed scenarios plus a randomized run,
// all checked against a game-level reference model kept in this file.
module tb_drop_engine;
    localparam int N = 4, X_W = 10, Y_W = 10, SCORE_W = 14;
    localparam int X_MIN = 64, SPAN = 9, FLOOR = 460, STEP = 2, GAP = 40, LIVES = 3;
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;

    logic clk = 1'b0, rst = 1'b1;
    logic tick = 1'b0, start = 1'b0, pause = 1'b0;
    logic [N-1:0] hit_in = '0;
    int errors = 0, checks = 0;

    drop_engine_if #(.N_ITEMS(N), .X_W(X_W), .Y_W(Y_W), .SCORE_W(SCORE_W)) bus ();

    assign bus.fall_tick = tick;
    assign bus.start     = start;
    assign bus.pause     = pause;
    assign bus.catch_hit = hit_in;

    drop_engine #(
        .N_ITEMS(N), .X_W(X_W), .Y_W(Y_W), .X_MIN(X_MIN), .X_SPAN_LG(SPAN),
        .FLOOR_Y(FLOOR), .FALL_STEP(STEP), .SPAWN_GAP(GAP), .LIVES(LIVES), .SCORE_W(SCORE_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model (game rules, one call per clock) ----------------
    int m_state, m_cnt, m_score, m_lives;
    bit m_start_q, m_pulse;
    bit [15:0] m_lfsr;
    bit m_act[N];
    int m_x[N], m_y[N], m_col[N];

    function automatic void model_clear_slots();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_col[i] = 0;
        end
    endfunction

    function automatic void model_reset();
        m_state = 0; m_cnt = 0; m_score = 0; m_lives = 0;
        m_start_q = 0; m_pulse = 0; m_lfsr = 16'hACE1;
        model_clear_slots();
    endfunction

    function automatic void model_step();
        bit rise;
        int sp, hits, misses, stp;
        rise = start && !m_start_q;
        m_start_q = start;
        m_pulse = 0;
        case (m_state)
            0: if (rise) begin
                model_clear_slots();
                m_score = 0; m_lives = LIVES; m_cnt = 0; m_state = 1;
            end
            1: begin
                stp = STEP;
`ifdef SPEEDUP_EN
                stp = (STEP + m_score / 16 > 4 * STEP) ? 4 * STEP : STEP + m_score / 16;
`endif
                sp = -1;
                if (m_cnt == GAP - 1)
                    for (int i = N - 1; i >= 0; i--) if (!m_act[i]) sp = i;
                hits = 0; misses = 0;
                for (int i = 0; i < N; i++) begin
                    if (m_act[i] && hit_in[i]) begin hits++; m_act[i] = 0; end
                    else if (m_act[i] && m_y[i] >= FLOOR) begin misses++; m_act[i] = 0; end
                    else if (m_act[i] && tick) m_y[i] += stp;
                end
                if (sp >= 0) begin
                    m_act[sp] = 1; m_x[sp] = X_MIN + (m_lfsr % (1 << SPAN));
                    m_y[sp] = 0; m_col[sp] = m_lfsr / 16384; m_cnt = 0;
                end else if (tick && m_cnt < GAP - 1) m_cnt++;
                m_score = (m_score + hits > SCORE_MAX) ? SCORE_MAX : m_score + hits;
                m_lives = (misses >= m_lives) ? 0 : m_lives - misses;
                m_pulse = (misses > 0);
                m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
                if (m_lives == 0) begin model_clear_slots(); m_state = 3; end
                else if (pause) m_state = 2;
            end
            2: if (!pause) m_state = 1;
            default: if (rise) m_state = 0;
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic logic [N-1:0] model_active();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_act[i];
        return v;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        model_reset();
        @(negedge clk); @(negedge clk);
        checks++; if (bus.game_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.game_state); end
        checks++; if (bus.item_active !== '0) begin errors++; $display("FAIL reset_active: got %b want 0", bus.item_active); end
        checks++; if (bus.item_x !== '0 || bus.item_y !== '0 || bus.item_color !== '0) begin errors++; $display("FAIL reset_items: x=%h y=%h c=%h want 0", bus.item_x, bus.item_y, bus.item_color); end
        checks++; if (bus.score !== '0 || bus.lives !== 2'd0 || bus.miss_pulse !== 1'b0) begin errors++; $display("FAIL reset_counters: score=%0d lives=%0d pulse=%b want 0", bus.score, bus.lives, bus.miss_pulse); end
        rst = 1'b0;
    endtask

    task automatic test_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
        checks++; if (bus.game_state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d want 1", bus.game_state); end
        checks++; if (bus.lives !== 2'd3 || bus.score !== '0) begin errors++; $display("FAIL start_counters: lives=%0d score=%0d want 3/0", bus.lives, bus.score); end
        checks++; if (bus.item_active !== '0) begin errors++; $display("FAIL start_active: got %b want 0", bus.item_active); end
    endtask

    task automatic test_spawn();
        tick = 1'b1;
        repeat (40) cycle();
        checks++; if (bus.item_active !== 4'b0001) begin errors++; $display("FAIL spawn0_active: got %b want 0001", bus.item_active); end
        checks++; if (bus.item_y[0 +: Y_W] !== '0) begin errors++; $display("FAIL spawn0_y: got %0d want 0", bus.item_y[0 +: Y_W]); end
        checks++;
        if (bus.item_x[0 +: X_W] < 10'd64 || bus.item_x[0 +: X_W] > 10'd575 || bus.item_x[0 +: X_W] !== X_W'(m_x[0])) begin
            errors++; $display("FAIL spawn0_x: got %0d want %0d in [64,575]", bus.item_x[0 +: X_W], m_x[0]);
        end
        checks++; if (bus.item_color[1:0] !== 2'(m_col[0])) begin errors++; $display("FAIL spawn0_color: got %0d want %0d", bus.item_color[1:0], m_col[0]); end
        repeat (40) cycle();
        checks++; if (bus.item_active !== 4'b0011) begin errors++; $display("FAIL spawn1_active: got %b want 0011", bus.item_active); end
        checks++; if (bus.item_y[0 +: Y_W] !== 10'd80 || bus.item_y[Y_W +: Y_W] !== '0) begin errors++; $display("FAIL spawn1_y: got y0=%0d y1=%0d want 80/0", bus.item_y[0 +: Y_W], bus.item_y[Y_W +: Y_W]); end
    endtask

    task automatic test_catch_miss();
        int guard = 0;
        tick = 1'b1;
        while (m_y[0] < FLOOR && guard < 400) begin
            cycle(); guard++;
            checks++; if (bus.item_y[0 +: Y_W] !== Y_W'(m_y[0])) begin errors++; $display("FAIL fall_y0: got %0d want %0d", bus.item_y[0 +: Y_W], m_y[0]); end
        end
        checks++; if (guard >= 400) begin errors++; $display("FAIL fall_budget: slot0 y=%0d never reached %0d", m_y[0], FLOOR); end
        hit_in = 4'b0110;
        cycle();
        hit_in = '0;
        checks++; if (bus.score !== 14'd2) begin errors++; $display("FAIL catch_score: got %0d want 2", bus.score); end
        checks++; if (bus.lives !== 2'd2) begin errors++; $display("FAIL miss_lives: got %0d want 2", bus.lives); end
        checks++; if (bus.miss_pulse !== 1'b1) begin errors++; $display("FAIL miss_pulse_high: got %b want 1", bus.miss_pulse); end
        checks++; if (bus.item_active !== 4'b1000) begin errors++; $display("FAIL catch_active: got %b want 1000", bus.item_active); end
        cycle();
        checks++; if (bus.miss_pulse !== 1'b0) begin errors++; $display("FAIL miss_pulse_low: got %b want 0", bus.miss_pulse); end
        checks++; if (bus.item_active !== 4'b1001 || bus.item_y[0 +: Y_W] !== '0 || bus.item_x[0 +: X_W] !== X_W'(m_x[0])) begin
            errors++; $display("FAIL respawn_freed: active=%b y0=%0d x0=%0d want 1001/0/%0d", bus.item_active, bus.item_y[0 +: Y_W], bus.item_x[0 +: X_W], m_x[0]);
        end
    endtask

    task automatic test_pause();
        int snap_y[N];
        int snap_score, guard;
        pause = 1'b1; tick = 1'b1;
        cycle();
        checks++; if (bus.game_state !== 2'd2) begin errors++; $display("FAIL pause_enter: got %0d want 2", bus.game_state); end
        for (int i = 0; i < N; i++) snap_y[i] = m_y[i];
        snap_score = m_score;
        for (int c = 0; c < 100; c++) begin
            hit_in = N'($urandom);
            cycle();
            checks++;
            for (int i = 0; i < N; i++)
                if (bus.item_y[i*Y_W +: Y_W] !== Y_W'(snap_y[i])) begin
                    errors++; $display("FAIL pause_freeze_y%0d: got %0d want %0d", i, bus.item_y[i*Y_W +: Y_W], snap_y[i]);
                end
            checks++; if (bus.score !== SCORE_W'(snap_score) || bus.game_state !== 2'd2) begin errors++; $display("FAIL pause_freeze: score=%0d state=%0d want %0d/2", bus.score, bus.game_state, snap_score); end
        end
        hit_in = '0; pause = 1'b0;
        cycle();
        checks++; if (bus.game_state !== 2'd1) begin errors++; $display("FAIL pause_exit: got %0d want 1", bus.game_state); end
        guard = 0;
        while (m_act[1] == 0 && guard < 100) begin
            cycle(); guard++;
        end
        checks++; if (bus.item_active !== model_active() || bus.item_x[X_W +: X_W] !== X_W'(m_x[1])) begin
            errors++; $display("FAIL resume_spawn: active=%b x1=%0d want %b/%0d", bus.item_active, bus.item_x[X_W +: X_W], model_active(), m_x[1]);
        end
    endtask

    task automatic test_game_over();
        int guard = 0;
        tick = 1'b1;
        while (m_state != 3 && guard < 3000) begin
            cycle(); guard++;
            checks++; if (bus.lives !== 2'(m_lives) || bus.miss_pulse !== m_pulse) begin errors++; $display("FAIL lives_track: lives=%0d pulse=%b want %0d/%b", bus.lives, bus.miss_pulse, m_lives, m_pulse); end
        end
        checks++; if (guard >= 3000) begin errors++; $display("FAIL over_budget: model never reached game over"); end
        checks++; if (bus.game_state !== 2'd3 || bus.lives !== 2'd0 || bus.item_active !== '0) begin
            errors++; $display("FAIL over_state: state=%0d lives=%0d active=%b want 3/0/0", bus.game_state, bus.lives, bus.item_active);
        end
        tick = 1'b0;
        start = 1'b1; cycle();
        checks++; if (bus.game_state !== 2'd0) begin errors++; $display("FAIL over_to_idle: got %0d want 0", bus.game_state); end
        start = 1'b0; cycle();
        start = 1'b1; cycle();
        start = 1'b0;
        checks++; if (bus.game_state !== 2'd1 || bus.lives !== 2'd3 || bus.score !== '0) begin
            errors++; $display("FAIL restart: state=%0d lives=%0d score=%0d want 1/3/0", bus.game_state, bus.lives, bus.score);
        end
    endtask

    task automatic test_async_reset();
        tick = 1'b1;
        repeat (45) cycle();
        checks++; if (bus.item_active !== model_active()) begin errors++; $display("FAIL prereset_active: got %b want %b", bus.item_active, model_active()); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.game_state !== 2'd0 || bus.item_active !== '0 || bus.lives !== 2'd0 || bus.score !== '0 || bus.miss_pulse !== 1'b0 || bus.item_y !== '0 || bus.item_x !== '0) begin
            errors++; $display("FAIL async_reset: state=%0d active=%b lives=%0d score=%0d want all 0", bus.game_state, bus.item_active, bus.lives, bus.score);
        end
        model_reset();
        tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        start = 1'b1; cycle(); start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) hit_in[i] = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 99) == 0) pause = ~pause;
            start = ($urandom_range(0, 59) == 0);
            cycle();
            checks++; if (bus.game_state !== 2'(m_state)) begin errors++; $display("FAIL rand_state c=%0d: got %0d want %0d", c, bus.game_state, m_state); end
            checks++; if (bus.item_active !== model_active()) begin errors++; $display("FAIL rand_active c=%0d: got %b want %b", c, bus.item_active, model_active()); end
            checks++; if (bus.score !== SCORE_W'(m_score) || bus.lives !== 2'(m_lives)) begin errors++; $display("FAIL rand_counters c=%0d: score=%0d lives=%0d want %0d/%0d", c, bus.score, bus.lives, m_score, m_lives); end
            checks++; if (bus.miss_pulse !== m_pulse) begin errors++; $display("FAIL rand_pulse c=%0d: got %b want %b", c, bus.miss_pulse, m_pulse); end
            for (int i = 0; i < N; i++)
                if (m_act[i]) begin
                    checks++;
                    if (bus.item_x[i*X_W +: X_W] !== X_W'(m_x[i]) || bus.item_y[i*Y_W +: Y_W] !== Y_W'(m_y[i]) || bus.item_color[i*2 +: 2] !== 2'(m_col[i])) begin
                        errors++; $display("FAIL rand_slot%0d c=%0d: x=%0d y=%0d col=%0d want %0d/%0d/%0d", i, c,
                            bus.item_x[i*X_W +: X_W], bus.item_y[i*Y_W +: Y_W], bus.item_color[i*2 +: 2], m_x[i], m_y[i], m_col[i]);
                    end
                end
        end
        tick = 1'b0; hit_in = '0; pause = 1'b0; start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_spawn();
        test_catch_miss();
        test_pause();
        test_game_over();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
